// File: rtl/cu_mem_port_arbiter_pkg.sv
// Shared types for the CU memory-port arbiter: FSM states, access owner and
// access direction encodings.
package cu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/cu_mem_port_arbiter_timer.sv
// Saturating access timer: cleared when an access starts, counts while it is
// outstanding, flags the last allowed cycle.
module cu_arb_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic soc_clk,
    input  logic soc_reset_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge soc_clk or negedge soc_reset_n) begin
        if (!soc_reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = en && (cnt == CNT_LAST);

endmodule

// File: rtl/cu_mem_port_arbiter.sv
// Shares the single CU->MMU access port between instruction fetch and
// load/store: arbitrates in IDLE, holds the latched request, routes the reply.
module cu_mem_port_arbiter
    import cu_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MASK_W       = 4,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic              soc_clk,
    input  logic              soc_reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [MASK_W-1:0] if_bits_to_access,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [MASK_W-1:0] mem_bits_to_access,
    input  logic              mem_read_or_write,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mmu_req,
    output logic [ADDR_W-1:0] mmu_addr,
    output logic [MASK_W-1:0] mmu_bits_to_access,
    output logic              mmu_read_or_write,
    output logic [DATA_W-1:0] mmu_wdata,
    input  logic              mmu_ack,
    input  logic              mmu_rvalid,
    input  logic [DATA_W-1:0] mmu_rdata,
    output logic              arb_timeout
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic              if_gnt_d, if_rvalid_d, mem_gnt_d, mem_rvalid_d;
    logic              mmu_req_d, mmu_rw_d, arb_timeout_d;
    logic [DATA_W-1:0] if_rdata_d, mem_rdata_d, mmu_wdata_d;
    logic [ADDR_W-1:0] mmu_addr_d;
    logic [MASK_W-1:0] mmu_mask_d;

    logic if_wins_c, fin_ok_c, fin_to_c;
    logic tmr_clr_c, tmr_en_c, tmr_expired_c;

    cu_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .soc_clk     (soc_clk),
        .soc_reset_n (soc_reset_n),
        .clr         (tmr_clr_c),
        .en          (tmr_en_c),
        .expired_c   (tmr_expired_c)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        starve_d      = starve_q;
        mmu_req_d     = mmu_req;
        mmu_addr_d    = mmu_addr;
        mmu_mask_d    = mmu_bits_to_access;
        mmu_rw_d      = mmu_read_or_write;
        mmu_wdata_d   = mmu_wdata;
        if_gnt_d      = 1'b0;
        mem_gnt_d     = 1'b0;
        if_rvalid_d   = 1'b0;
        mem_rvalid_d  = 1'b0;
        arb_timeout_d = 1'b0;
        if_rdata_d    = if_rdata;
        mem_rdata_d   = mem_rdata;
        if_wins_c     = 1'b0;
        fin_ok_c      = 1'b0;
        fin_to_c      = 1'b0;
        tmr_clr_c     = 1'b0;
        tmr_en_c      = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // MEM wins ties unless IF has lost STARVE_LIMIT times in a row
                if (if_req || mem_req) begin
                    if_wins_c   = if_req && (!mem_req || (starve_q == STARVE_MAX));
                    owner_d     = if_wins_c ? OWN_IF : OWN_MEM;
                    mmu_addr_d  = if_wins_c ? if_addr : mem_addr;
                    mmu_mask_d  = if_wins_c ? if_bits_to_access : mem_bits_to_access;
                    mmu_rw_d    = if_wins_c ? RW_READ : mem_read_or_write;
                    mmu_wdata_d = if_wins_c ? '0 : mem_wdata;
                    if_gnt_d    = if_wins_c;
                    mem_gnt_d   = !if_wins_c;
                    mmu_req_d   = 1'b1;
                    tmr_clr_c   = 1'b1;
                    state_d     = ARB_REQ;
                end
                if (!if_req || if_wins_c) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            ARB_REQ: begin
                tmr_en_c = 1'b1;
                if (tmr_expired_c) begin
                    fin_to_c = 1'b1;
                end else if (mmu_ack) begin
                    mmu_req_d = 1'b0;
                    state_d   = ARB_RESP;
                end
            end
            ARB_RESP: begin
                tmr_en_c = 1'b1;
                if (mmu_rvalid) begin
                    fin_ok_c = 1'b1;
                end else if (tmr_expired_c) begin
                    fin_to_c = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (fin_to_c) begin
            mmu_req_d     = 1'b0;
            arb_timeout_d = 1'b1;
        end
        // Completion (normal or forced) is reported to the owner only
        if (fin_ok_c || fin_to_c) begin
            state_d = ARB_IDLE;
            if (owner_q == OWN_IF) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = fin_to_c ? '0 : mmu_rdata;
            end else begin
                mem_rvalid_d = 1'b1;
                mem_rdata_d  = (fin_to_c || (mmu_read_or_write == RW_WRITE)) ? '0 : mmu_rdata;
            end
        end
    end

    always_ff @(posedge soc_clk or negedge soc_reset_n) begin
        if (!soc_reset_n) begin
            state_q            <= ARB_IDLE;
            owner_q            <= OWN_IF;
            starve_q           <= '0;
            mmu_req            <= 1'b0;
            mmu_addr           <= '0;
            mmu_bits_to_access <= '0;
            mmu_read_or_write  <= 1'b0;
            mmu_wdata          <= '0;
            if_gnt             <= 1'b0;
            mem_gnt            <= 1'b0;
            if_rvalid          <= 1'b0;
            mem_rvalid         <= 1'b0;
            arb_timeout        <= 1'b0;
            if_rdata           <= '0;
            mem_rdata          <= '0;
        end else begin
            state_q            <= state_d;
            owner_q            <= owner_d;
            starve_q           <= starve_d;
            mmu_req            <= mmu_req_d;
            mmu_addr           <= mmu_addr_d;
            mmu_bits_to_access <= mmu_mask_d;
            mmu_read_or_write  <= mmu_rw_d;
            mmu_wdata          <= mmu_wdata_d;
            if_gnt             <= if_gnt_d;
            mem_gnt            <= mem_gnt_d;
            if_rvalid          <= if_rvalid_d;
            mem_rvalid         <= mem_rvalid_d;
            arb_timeout        <= arb_timeout_d;
            if_rdata           <= if_rdata_d;
            mem_rdata          <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_cu_mem_port_arbiter.sv
// Self-checking bench for cu_mem_port_arbiter: vector table for arbitration,
// hand sequences for delayed ack, timeout, reset and early rvalid.
module tb_cu_mem_port_arbiter;
    import cu_pkg::*;

    localparam int unsigned TIMEOUT = 64;

    logic        soc_clk = 1'b0;
    logic        soc_reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [3:0]  if_bits_to_access = 4'hF;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_bits_to_access = '0;
    logic        mem_read_or_write = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mmu_req;
    logic [31:0] mmu_addr;
    logic [3:0]  mmu_bits_to_access;
    logic        mmu_read_or_write;
    logic [31:0] mmu_wdata;
    logic        mmu_ack = 1'b0;
    logic        mmu_rvalid = 1'b0;
    logic [31:0] mmu_rdata = '0;
    logic        arb_timeout;

    cu_mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MASK_W(4), .STARVE_LIMIT(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .soc_clk            (soc_clk),
        .soc_reset_n        (soc_reset_n),
        .if_req             (if_req),
        .if_addr            (if_addr),
        .if_bits_to_access  (if_bits_to_access),
        .if_gnt             (if_gnt),
        .if_rvalid          (if_rvalid),
        .if_rdata           (if_rdata),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_bits_to_access (mem_bits_to_access),
        .mem_read_or_write  (mem_read_or_write),
        .mem_wdata          (mem_wdata),
        .mem_gnt            (mem_gnt),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata),
        .mmu_req            (mmu_req),
        .mmu_addr           (mmu_addr),
        .mmu_bits_to_access (mmu_bits_to_access),
        .mmu_read_or_write  (mmu_read_or_write),
        .mmu_wdata          (mmu_wdata),
        .mmu_ack            (mmu_ack),
        .mmu_rvalid         (mmu_rvalid),
        .mmu_rdata          (mmu_rdata),
        .arb_timeout        (arb_timeout)
    );

    always #5 soc_clk = ~soc_clk;

    logic any_out;
    assign any_out = |{if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata, mmu_req,
                       mmu_addr, mmu_bits_to_access, mmu_read_or_write, mmu_wdata, arb_timeout};

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
        logic        tmo;
    } exp_t;

    typedef struct {
        logic        if_rq;
        logic        mem_rq;
        logic        mem_rw;
        logic [31:0] if_a;
        logic [31:0] mem_a;
        logic [3:0]  mask;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        exp_mem;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    // Wait for the grant, check the latched fields, then play the MMU side
    task automatic access(input string name, input logic exp_mem, input logic [31:0] ea,
                          input logic [3:0] em, input logic erw, input logic [31:0] ewd,
                          input logic [31:0] rd, input int ack_dly, input logic drop);
        int w = 0;
        do begin
            tick();
            w++;
        end while (!(if_gnt || mem_gnt) && w < 40);
        chk({name, " gnt latency"}, 96'(w), 96'd1);
        chk({name, " gnt owner"}, {94'd0, if_gnt, mem_gnt}, exp_mem ? 96'd1 : 96'd2);
        chk({name, " mmu fields"}, {mmu_req, mmu_addr, mmu_bits_to_access, mmu_read_or_write},
            {1'b1, ea, em, erw});
        if (exp_mem) chk({name, " mmu_wdata"}, 96'(mmu_wdata), 96'(ewd));
        if (drop) begin
            if_req  = 1'b0;
            mem_req = 1'b0;
        end
        sb_q.push_back('{exp_mem, (exp_mem && erw == RW_WRITE) ? 32'h0 : rd, 1'b0});
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk({name, " stable before ack"},
                {mmu_req, mmu_addr, mmu_bits_to_access, mmu_read_or_write, exp_mem ? mmu_wdata : 32'h0},
                {1'b1, ea, em, erw, exp_mem ? ewd : 32'h0});
        end
        mmu_ack = 1'b1;
        tick();
        mmu_ack = 1'b0;
        chk({name, " mmu_req after ack"}, 96'(mmu_req), 96'd0);
        mmu_rvalid = 1'b1;
        mmu_rdata  = rd;
        tick();
        mmu_rvalid = 1'b0;
    endtask

    // Scoreboard: every owner rvalid must match the oldest outstanding access
    initial begin
        exp_t e;
        forever begin
            @(negedge soc_clk);
            if (soc_reset_n && (if_rvalid || mem_rvalid)) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb unexpected rvalid: if=%0b mem=%0b expected none", if_rvalid, mem_rvalid);
                end else begin
                    e = sb_q.pop_front();
                    if ((if_rvalid && mem_rvalid) || (mem_rvalid != e.is_mem) ||
                        ((e.is_mem ? mem_rdata : if_rdata) !== e.rdata) || (arb_timeout !== e.tmo)) begin
                        errors++;
                        $display("FAIL sb response: if_rv=%0b mem_rv=%0b rdata=0x%0h tmo=%0b expected mem=%0b rdata=0x%0h tmo=%0b",
                                 if_rvalid, mem_rvalid, e.is_mem ? mem_rdata : if_rdata, arb_timeout,
                                 e.is_mem, e.rdata, e.tmo);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hi;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'h0,    32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_1000, 4'h1, 32'h0,    32'h1111_1111, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_1004, 4'h3, 32'hA5A5, 32'h2222_2222, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_1008, 4'hC, 32'h0,    32'h3333_3333, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_100C, 4'h8, 32'h005A, 32'h4444_4444, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_1010, 4'h6, 32'h0,    32'h5555_5555, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_1014, 4'h6, 32'h0,    32'h6666_6666, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_2000, 4'hE, 32'h0077, 32'h7777_7777, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0000_2000, 4'h1, 32'h0,    32'h8888_8888, 1'b0};

        tick();
        chk("reset outputs", 96'(any_out), 96'd0);
        tick();
        soc_reset_n = 1'b1;
        tick();
        chk("post-reset outputs", 96'(any_out), 96'd0);

        // Single accesses and tie arbitration with starvation override
        for (int i = 0; i < 9; i++) begin
            if_req             = vecs[i].if_rq;
            mem_req            = vecs[i].mem_rq;
            if_addr            = vecs[i].if_a;
            mem_addr           = vecs[i].mem_a;
            mem_bits_to_access = vecs[i].mask;
            mem_read_or_write  = vecs[i].mem_rw;
            mem_wdata          = vecs[i].wd;
            access($sformatf("vec%0d", i), vecs[i].exp_mem,
                   vecs[i].exp_mem ? vecs[i].mem_a : vecs[i].if_a,
                   vecs[i].exp_mem ? vecs[i].mask : 4'hF,
                   vecs[i].exp_mem ? vecs[i].mem_rw : RW_READ,
                   vecs[i].wd, vecs[i].rd, 0, i == 8);
            chk($sformatf("vec%0d rvalid", i), {94'd0, if_rvalid, mem_rvalid},
                vecs[i].exp_mem ? 96'd1 : 96'd2);
            chk($sformatf("vec%0d rdata", i), 96'(vecs[i].exp_mem ? mem_rdata : if_rdata),
                96'((vecs[i].exp_mem && vecs[i].mem_rw) ? 32'h0 : vecs[i].rd));
        end
        tick();

        // MEM write with a 7-cycle delayed ack
        mem_req = 1'b1; mem_addr = 32'h200; mem_bits_to_access = 4'b0011;
        mem_read_or_write = RW_WRITE; mem_wdata = 32'h1234;
        access("wr_delay", 1'b1, 32'h200, 4'b0011, RW_WRITE, 32'h1234, 32'hFFFF_FFFF, 7, 1'b1);
        chk("wr_delay rvalid/rdata", {mem_rvalid, mem_rdata}, {1'b1, 32'h0});
        tick();

        // No ack ever; an ack arriving in the expiry cycle must lose to the timeout
        mem_req = 1'b1; mem_addr = 32'h300; mem_read_or_write = RW_READ; mmu_rdata = 32'hFFFF_FFFF;
        tick();
        chk("tmo gnt", 96'(mem_gnt), 96'd1);
        mem_req = 1'b0;
        sb_q.push_back('{1'b1, 32'h0, 1'b1});
        hi = 0;
        while (mmu_req && hi < 200) begin
            hi++;
            if (hi == TIMEOUT) mmu_ack = 1'b1;
            tick();
            mmu_ack = 1'b0;
        end
        chk("tmo mmu_req cycles", 96'(hi), 96'(TIMEOUT));
        chk("tmo completion", {arb_timeout, mem_rvalid, mem_rdata}, {1'b1, 1'b1, 32'h0});
        if_req = 1'b1; if_addr = 32'h110;
        access("after_tmo", 1'b0, 32'h110, 4'hF, RW_READ, 32'h0, 32'hCAFE_0001, 0, 1'b1);
        tick();

        // Reset while in REQ: mmu_req and the grant pulse drop at once
        if_req = 1'b1; if_addr = 32'h120;
        tick();
        chk("rst_req gnt", {mmu_req, if_gnt}, {1'b1, 1'b1});
        if_req = 1'b0;
        soc_reset_n = 1'b0;
        #1;
        chk("rst_req outputs", 96'(any_out), 96'd0);
        tick();
        soc_reset_n = 1'b1;
        mmu_ack = 1'b1;
        tick();
        mmu_ack = 1'b0;
        chk("rst_req stray ack", {mmu_req, if_gnt, mem_gnt}, 96'd0);

        // Reset while in RESP, then a stray rvalid
        mem_req = 1'b1; mem_addr = 32'h400;
        tick();
        chk("rst_resp gnt", 96'(mem_gnt), 96'd1);
        mem_req = 1'b0;
        mmu_ack = 1'b1;
        tick();
        mmu_ack = 1'b0;
        soc_reset_n = 1'b0;
        #1;
        chk("rst_resp outputs", 96'(any_out), 96'd0);
        tick();
        soc_reset_n = 1'b1;
        mmu_rvalid = 1'b1; mmu_rdata = 32'h5555;
        tick();
        mmu_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_resp no rvalid", {if_rvalid, mem_rvalid, mmu_req}, 96'd0);
        end

        // rvalid during REQ is ignored
        mem_req = 1'b1; mem_addr = 32'h600; mem_bits_to_access = 4'hF; mem_read_or_write = RW_READ;
        tick();
        chk("early_rv gnt", 96'(mem_gnt), 96'd1);
        mem_req = 1'b0;
        sb_q.push_back('{1'b1, 32'h600D, 1'b0});
        mmu_rvalid = 1'b1; mmu_rdata = 32'hBAD;
        tick();
        mmu_rvalid = 1'b0;
        chk("early_rv still req", {mmu_req, mem_rvalid}, {1'b1, 1'b0});
        mmu_ack = 1'b1;
        tick();
        mmu_ack = 1'b0;
        chk("early_rv resp wait", {mmu_req, mem_rvalid}, 96'd0);
        mmu_rvalid = 1'b1; mmu_rdata = 32'h600D;
        tick();
        mmu_rvalid = 1'b0;
        chk("early_rv delivered", {mem_rvalid, mem_rdata}, {1'b1, 32'h600D});
        tick();
        tick();

        chk("sb drained", 96'(sb_q.size()), 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
